// File: rtl/dac_stream_upsampler.sv
// dac_stream_upsampler
//
// Zero-order-hold upsampler for the DAC path, rf_clk domain. It sits between the clock-crossing
// AXIS FIFO and the RF data converter. Each input beat carries NUM_SAMPLES samples. Every sample
// is repeated R times (R = 1, 2 or 4, chosen per input beat), so one input beat becomes R output
// beats of NUM_SAMPLES samples each.
//
// Pipeline:
//   stage 1: hold register (data, hold_valid, phase, latched R)
//   stage 2: registered AXIS output (m_axis_tdata, m_axis_tvalid)
//
// Ports:
//   rf_clk          rf data clock, rising edge
//   rf_rst          asynchronous active-high reset
//   enable          stream enable; low flushes the hold stage and blocks input
//   rate_sel        0: R=1, 1: R=2, 2: R=4, 3: R=1; sampled only when an input beat is accepted
//   clear_status    single-cycle clear of underflow flag/counter (wins over a same-cycle event)
//   s_axis_*        input stream, sample i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
//   m_axis_*        expanded output stream
//   active_rate     R latched for the beat currently in the hold register
//   underflow_flag  sticky: the consumer was ready but no beat was valid, after priming
//   underflow_cnt   saturating count of underflow cycles
module dac_stream_upsampler #(
    parameter int unsigned SAMPLE_WIDTH = 8,
    parameter int unsigned NUM_SAMPLES  = 32,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                  rf_clk,
    input  logic                                  rf_rst,
    input  logic                                  enable,
    input  logic [1:0]                            rate_sel,
    input  logic                                  clear_status,
    input  logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0]   s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [NUM_SAMPLES*SAMPLE_WIDTH-1:0]   m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic [2:0]                            active_rate,
    output logic                                  underflow_flag,
    output logic [CNT_WIDTH-1:0]                  underflow_cnt
);

    localparam int unsigned DataWidth = NUM_SAMPLES * SAMPLE_WIDTH;
    localparam int unsigned IdxWidth  = $clog2(NUM_SAMPLES);

    // ------------------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------------------
    logic [DataWidth-1:0] hold_data_q, hold_data_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [1:0]           phase_q, phase_d;
    logic [2:0]           rate_q, rate_d;        // R itself: 1, 2 or 4
    logic                 primed_q, primed_d;
    logic [DataWidth-1:0] m_tdata_q, m_tdata_d;
    logic                 m_tvalid_q, m_tvalid_d;
    logic                 uf_flag_q, uf_flag_d;
    logic [CNT_WIDTH-1:0] uf_cnt_q, uf_cnt_d;

    // ------------------------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------------------------
    logic       out_adv;
    logic       last_phase;
    logic       accept;
    logic       load_out;
    logic       underflow_evt;
    logic [2:0] rate_dec;

    assign out_adv = !m_tvalid_q || m_axis_tready;

    always_comb begin
        last_phase = (phase_q == 2'd0);
        case (rate_q)
            3'd2:    last_phase = (phase_q == 2'd1);
            3'd4:    last_phase = (phase_q == 2'd3);
            default: last_phase = (phase_q == 2'd0);
        endcase
    end

    always_comb begin
        case (rate_sel)
            2'd1:    rate_dec = 3'd2;
            2'd2:    rate_dec = 3'd4;
            default: rate_dec = 3'd1;   // includes the reserved encoding
        endcase
    end

    // Gated by rf_rst so ready reads low while reset is held, even with enable high.
    assign s_axis_tready = !rf_rst && enable && (!hold_valid_q || (out_adv && last_phase));
    assign accept        = s_axis_tvalid && s_axis_tready;

    // A held beat only moves to the output while enabled; a disabled stream drains instead.
    assign load_out      = out_adv && enable && hold_valid_q;

    assign underflow_evt = enable && primed_q && m_axis_tready && !m_tvalid_q;

    // ------------------------------------------------------------------------------------------
    // Sample expansion: output lane j takes hold sample (phase*NUM_SAMPLES/R + j/R)
    // ------------------------------------------------------------------------------------------
    logic [SAMPLE_WIDTH-1:0] hold_smp [NUM_SAMPLES];
    logic [DataWidth-1:0]    expanded;
    int unsigned             phase_int;

    assign phase_int = 32'(phase_q);

    for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_lane
        logic [IdxWidth-1:0] src_idx;

        assign hold_smp[g] = hold_data_q[g*SAMPLE_WIDTH +: SAMPLE_WIDTH];

        always_comb begin
            case (rate_q)
                3'd2:    src_idx = IdxWidth'(phase_int * (NUM_SAMPLES / 2) + g / 2);
                3'd4:    src_idx = IdxWidth'(phase_int * (NUM_SAMPLES / 4) + g / 4);
                default: src_idx = IdxWidth'(g);
            endcase
        end

        assign expanded[g*SAMPLE_WIDTH +: SAMPLE_WIDTH] = hold_smp[src_idx];
    end

    // ------------------------------------------------------------------------------------------
    // Stage 1: hold register
    // ------------------------------------------------------------------------------------------
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        phase_d      = phase_q;
        rate_d       = rate_q;
        if (!enable) begin
            // Partially expanded beat is discarded.
            hold_valid_d = 1'b0;
            phase_d      = 2'd0;
        end else if (accept) begin
            // Also covers the last phase being consumed on the same edge as the refill.
            hold_data_d  = s_axis_tdata;
            hold_valid_d = 1'b1;
            phase_d      = 2'd0;
            rate_d       = rate_dec;
        end else if (load_out) begin
            if (last_phase) begin
                hold_valid_d = 1'b0;
                phase_d      = 2'd0;
            end else begin
                phase_d = phase_q + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Stage 2: registered output
    // ------------------------------------------------------------------------------------------
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        if (out_adv) begin
            if (load_out) begin
                m_tdata_d  = expanded;
                m_tvalid_d = 1'b1;
            end else begin
                m_tvalid_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Underflow status
    // ------------------------------------------------------------------------------------------
    always_comb begin
        primed_d = primed_q;
        if (!enable) begin
            primed_d = 1'b0;
        end else if (m_tvalid_q && m_axis_tready) begin
            primed_d = 1'b1;
        end
    end

    always_comb begin
        uf_flag_d = uf_flag_q;
        uf_cnt_d  = uf_cnt_q;
        if (clear_status) begin
            uf_flag_d = 1'b0;
            uf_cnt_d  = '0;
        end else if (underflow_evt) begin
            uf_flag_d = 1'b1;
            if (uf_cnt_q != {CNT_WIDTH{1'b1}}) begin
                uf_cnt_d = uf_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            phase_q      <= 2'd0;
            rate_q       <= 3'd1;
            primed_q     <= 1'b0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            uf_flag_q    <= 1'b0;
            uf_cnt_q     <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            phase_q      <= phase_d;
            rate_q       <= rate_d;
            primed_q     <= primed_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            uf_flag_q    <= uf_flag_d;
            uf_cnt_q     <= uf_cnt_d;
        end
    end

    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tvalid  = m_tvalid_q;
    assign active_rate    = rate_q;
    assign underflow_flag = uf_flag_q;
    assign underflow_cnt  = uf_cnt_q;

endmodule

// File: tb/tb_dac_stream_upsampler.sv
// tb_dac_stream_upsampler
//
// Directed bench for dac_stream_upsampler with default parameters (8-bit samples, 32 per beat,
// 16-bit underflow counter). Inputs change 1 time unit after the rising edge; outputs are
// compared at that point, or 1 unit later for the combinational s_axis_tready.
module tb_dac_stream_upsampler;

    localparam int SW = 8;
    localparam int NS = 32;
    localparam int DW = SW * NS;

    logic          rf_clk;
    logic          rf_rst;
    logic          enable;
    logic [1:0]    rate_sel;
    logic          clear_status;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [2:0]    active_rate;
    logic          underflow_flag;
    logic [15:0]   underflow_cnt;

    int n_vec;
    int n_err;

    dac_stream_upsampler #(
        .SAMPLE_WIDTH (SW),
        .NUM_SAMPLES  (NS),
        .CNT_WIDTH    (16)
    ) dut (
        .rf_clk         (rf_clk),
        .rf_rst         (rf_rst),
        .enable         (enable),
        .rate_sel       (rate_sel),
        .clear_status   (clear_status),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .active_rate    (active_rate),
        .underflow_flag (underflow_flag),
        .underflow_cnt  (underflow_cnt)
    );

    initial rf_clk = 1'b0;
    always #5 rf_clk = ~rf_clk;

    // Input beat whose sample i equals base + i.
    function automatic logic [DW-1:0] ramp(input int base);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < NS; i++) v[i*SW +: SW] = SW'(base + i);
        return v;
    endfunction

    // Output beat b of a ramp(base) input repeated r times: the output stream is the input
    // stream with every sample written r times, so stream position k carries base + k/r.
    function automatic logic [DW-1:0] rep(input int base, input int r, input int b);
        logic [DW-1:0] v;
        v = '0;
        for (int j = 0; j < NS; j++) v[j*SW +: SW] = SW'(base + (b * NS + j) / r);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rf_clk);
        #1;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rf_rst        = 1'b1;
        enable        = 1'b0;
        rate_sel      = 2'd0;
        clear_status  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge rf_clk);
        #1;
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata, 0);
        chk("rst_active_rate", active_rate, 1);
        chk("rst_uf_flag", underflow_flag, 0);
        chk("rst_uf_cnt", underflow_cnt, 0);
        @(negedge rf_clk);
        rf_rst = 1'b0;
        tick();

        // ---------------- R=1: 8 back-to-back beats ----------------
        enable        = 1'b1;
        rate_sel      = 2'd0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = ramp(0);
        #1 chk("r1_ready_idle", s_axis_tready, 1);
        tick();
        chk("r1_latency_tvalid", m_axis_tvalid, 0);
        chk("r1_active_rate", active_rate, 1);
        for (int b = 1; b <= 8; b++) begin
            s_axis_tvalid = (b < 8);
            s_axis_tdata  = ramp(b * 32);
            #1 chk("r1_ready_full", s_axis_tready, 1);
            tick();
            chk("r1_tvalid", m_axis_tvalid, 1);
            chk("r1_data", m_axis_tdata, ramp((b - 1) * 32));
        end
        tick();
        chk("r1_drain", m_axis_tvalid, 0);
        chk("r1_no_underflow", underflow_cnt, 0);
        m_axis_tready = 1'b0;

        // ---------------- R=2 ----------------
        rate_sel      = 2'd1;
        s_axis_tdata  = ramp(0);
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        #1 chk("r2_ready_idle", s_axis_tready, 1);
        tick();
        chk("r2_active_rate", active_rate, 2);
        s_axis_tdata = ramp(8'h80);
        #1 chk("r2_ready_phase0", s_axis_tready, 0);
        tick();
        chk("r2_beat0", m_axis_tdata, rep(0, 2, 0));
        chk("r2_beat0_tvalid", m_axis_tvalid, 1);
        chk("r2_ready_last_phase", s_axis_tready, 1);
        tick();
        chk("r2_beat1", m_axis_tdata, rep(0, 2, 1));
        s_axis_tvalid = 1'b0;
        tick();
        chk("r2_next_beat0", m_axis_tdata, rep(8'h80, 2, 0));
        tick();
        chk("r2_next_beat1", m_axis_tdata, rep(8'h80, 2, 1));
        tick();
        chk("r2_drain", m_axis_tvalid, 0);

        // ---------------- R=4, rate_sel changed mid-beat ----------------
        rate_sel      = 2'd2;
        s_axis_tdata  = ramp(0);
        s_axis_tvalid = 1'b1;
        tick();
        chk("r4_active_rate", active_rate, 4);
        s_axis_tdata = ramp(8'h40);
        tick();
        chk("r4_beat0", m_axis_tdata, rep(0, 4, 0));
        rate_sel = 2'd0;
        tick();
        chk("r4_beat1", m_axis_tdata, rep(0, 4, 1));
        chk("r4_rate_held", active_rate, 4);
        tick();
        chk("r4_beat2", m_axis_tdata, rep(0, 4, 2));
        tick();
        chk("r4_beat3", m_axis_tdata, rep(0, 4, 3));
        chk("r4_rate_next", active_rate, 1);
        s_axis_tvalid = 1'b0;
        tick();
        chk("r4_next_r1_data", m_axis_tdata, ramp(8'h40));
        chk("r4_next_r1_tvalid", m_axis_tvalid, 1);
        tick();
        chk("r4_drain", m_axis_tvalid, 0);

        // ---------------- backpressure, R=2, tready 1,0,0,1,1 ----------------
        rate_sel      = 2'd1;
        s_axis_tdata  = ramp(0);
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tdata = ramp(8'h40);
        tick();
        chk("bp_a0", m_axis_tdata, rep(0, 2, 0));
        m_axis_tready = 1'b1;
        tick();
        chk("bp_a1", m_axis_tdata, rep(0, 2, 1));
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        chk("bp_stall1_data", m_axis_tdata, rep(0, 2, 1));
        chk("bp_stall1_tvalid", m_axis_tvalid, 1);
        tick();
        chk("bp_stall2_data", m_axis_tdata, rep(0, 2, 1));
        m_axis_tready = 1'b1;
        tick();
        chk("bp_b0", m_axis_tdata, rep(8'h40, 2, 0));
        tick();
        chk("bp_b1", m_axis_tdata, rep(8'h40, 2, 1));
        tick();
        chk("bp_drain", m_axis_tvalid, 0);

        // ---------------- underflow ----------------
        enable        = 1'b0;
        clear_status  = 1'b1;
        m_axis_tready = 1'b0;
        rate_sel      = 2'd0;
        tick();
        clear_status  = 1'b0;
        enable        = 1'b1;
        s_axis_tdata  = ramp(8'hA0);
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        chk("uf_cleared_cnt", underflow_cnt, 0);
        chk("uf_cleared_flag", underflow_flag, 0);
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("uf_prime_beat", m_axis_tdata, ramp(8'hA0));
        tick();
        chk("uf_none_before_primed", underflow_cnt, 0);
        repeat (5) tick();
        chk("uf_cnt_5", underflow_cnt, 5);
        chk("uf_flag_set", underflow_flag, 1);
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        chk("uf_clear_cnt", underflow_cnt, 0);
        chk("uf_clear_flag", underflow_flag, 0);
        repeat (65535) tick();
        chk("uf_cnt_max", underflow_cnt, 16'hFFFF);
        repeat (3) tick();
        chk("uf_cnt_saturated", underflow_cnt, 16'hFFFF);
        chk("uf_flag_sticky", underflow_flag, 1);

        // ---------------- enable dropped during phase 1 of R=4 ----------------
        rate_sel      = 2'd2;
        s_axis_tdata  = ramp(0);
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("en_beat0", m_axis_tdata, rep(0, 4, 0));
        enable        = 1'b0;
        m_axis_tready = 1'b0;
        #1 chk("en_ready_low", s_axis_tready, 0);
        tick();
        chk("en_out_kept_tvalid", m_axis_tvalid, 1);
        chk("en_out_kept_data", m_axis_tdata, rep(0, 4, 0));
        m_axis_tready = 1'b1;
        tick();
        chk("en_no_further_output", m_axis_tvalid, 0);
        enable = 1'b1;
        #1 chk("en_hold_discarded", s_axis_tready, 1);
        tick();
        chk("en_still_idle", m_axis_tvalid, 0);

        // ---------------- asynchronous reset mid-beat ----------------
        s_axis_tdata  = ramp(0);
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("rst_pre_tvalid", m_axis_tvalid, 1);
        #2 rf_rst = 1'b1;
        #1;
        chk("rst_mid_s_tready", s_axis_tready, 0);
        chk("rst_mid_m_tvalid", m_axis_tvalid, 0);
        chk("rst_mid_m_tdata", m_axis_tdata, 0);
        chk("rst_mid_active_rate", active_rate, 1);
        chk("rst_mid_uf_flag", underflow_flag, 0);
        chk("rst_mid_uf_cnt", underflow_cnt, 0);
        tick();
        @(negedge rf_clk);
        rf_rst = 1'b0;
        #1 chk("rst_release_ready", s_axis_tready, 1);
        rate_sel      = 2'd0;
        s_axis_tdata  = ramp(8'h33);
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        chk("rst_after_data", m_axis_tdata, ramp(8'h33));
        chk("rst_after_tvalid", m_axis_tvalid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac_stream_upsampler.md
Name: dac_stream_upsampler

Overview:
Parametrised sample-repeat (zero-order-hold upsampling) stage for the DAC path. It sits in the rf_clk domain between the clock-crossing AXIS FIFO and the RF data converter input. Each input beat holds NUM_SAMPLES samples. Each sample is repeated R times, with R selectable at runtime as 1, 2 or 4, so one input beat expands into R output beats. The block adds enable control and underflow status for debug.

Parameters:
SAMPLE_WIDTH, 8, bits per DAC sample
NUM_SAMPLES, 32, samples per beat on both input and output; must be divisible by 4
CNT_WIDTH, 16, width of the underflow counter

Ports:
rf_clk  input  1  rf data clock; all logic on rising edge
rf_rst  input  1  asynchronous, active-high reset
enable  input  1  stream enable
rate_sel  input  2  0: R=1, 1: R=2, 2: R=4, 3: reserved, treated as R=1
clear_status  input  1  single-cycle clear of underflow status
s_axis_tdata  input  NUM_SAMPLES*SAMPLE_WIDTH  input samples; sample i at bits [i*SW +: SW]
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  NUM_SAMPLES*SAMPLE_WIDTH  expanded samples
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
active_rate  output  3  R latched for the beat in the hold register (1, 2 or 4)
underflow_flag  output  1  sticky underflow indicator
underflow_cnt  output  CNT_WIDTH  saturating count of underflow cycles

Behaviour:
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0
  - active_rate=1, underflow_flag=0, underflow_cnt=0
  - internal state: hold_valid=0, phase=0, primed=0
- Datapath:
  - Stage 1 is a hold register with hold_valid, phase counter and latched R.
  - Stage 2 is the registered output (m_axis_tdata, m_axis_tvalid).
- Output advance: out_adv = !m_axis_tvalid || m_axis_tready.
- Output load: on out_adv with hold_valid=1:
  - m_axis_tdata sample j = hold sample (phase*NUM_SAMPLES/R + j/R), integer division.
  - Set m_axis_tvalid=1.
  - If phase==R-1: phase returns to 0 and hold_valid is cleared, unless a new beat is accepted on the same edge. Otherwise phase increments.
- Output drain: on out_adv with hold_valid=0, m_axis_tvalid goes to 0.
- Input ready: s_axis_tready = enable && (!hold_valid || (out_adv && phase==R-1)). It is combinational from registered state.
- Input accept: on s_axis_tvalid && s_axis_tready:
  - Load hold register and set hold_valid=1, phase=0.
  - Latch R from rate_sel; active_rate updates on this edge.
- rate_sel is sampled only at input acceptance. Changes mid-beat take effect on the next input beat.
- Latency: input accepted at edge E0 gives m_axis_tvalid=1 after E1.
- Throughput: full at R=1 (one beat per cycle with continuous tvalid/tready). At R=2 and R=4, input is accepted 1 in R cycles.
- AXIS rule: m_axis_tdata and m_axis_tvalid are stable while tvalid=1 and tready=0.
- enable=0:
  - s_axis_tready=0.
  - hold_valid is cleared and phase set to 0 on the next edge; partially expanded beats are discarded.
  - A beat already in the output register stays valid until accepted; no new beat is loaded.
  - primed is cleared.
- primed is set on the first output handshake after enable rises.
- Underflow event: enable && primed && m_axis_tready && !m_axis_tvalid, sampled each cycle.
  - Sets underflow_flag.
  - Increments underflow_cnt, saturating at all-ones.
- clear_status zeroes the flag and counter on the next edge. It has priority over a simultaneous underflow event.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). After reset release, s_axis_tready rises on the first cycle with enable=1.

Test Plan:
- R=1: rate_sel=0, enable=1, input sample i = i (0x00..0x1F), m_axis_tready=1 → one output beat identical to input, m_axis_tvalid 1 cycle after acceptance; 8 back-to-back beats give 8 consecutive valid cycles.
- R=2: rate_sel=1, same input → beat0 = 00 00 01 01 .. 0F 0F, beat1 = 10 10 .. 1F 1F; s_axis_tready low during beat0 output.
- R=4: rate_sel=2, same input → 4 beats; beat0 = 00×4..07×4, beat3 = 18×4..1F×4; active_rate=4. Toggle rate_sel to 0 during beat1 → current beat still yields 4 outputs, the next input yields 1.
- Backpressure: R=2, m_axis_tready pattern 1,0,0,1,1 → m_axis_tdata stable while stalled; no beats lost or duplicated.
- Underflow: prime with 1 beat, then stall input 5 cycles with m_axis_tready=1 → underflow_cnt=5, flag=1; clear_status coincident with a 6th underflow cycle → cnt=0, flag=0. Force 0xFFFF events → counter holds 0xFFFF.
- Enable/reset: drop enable during phase 1 of R=4 → remaining phases discarded, s_axis_tready=0, no further output. Assert rf_rst mid-beat → all outputs at reset values immediately.
